// File: rtl/fp_sub_seq.sv
// Sequential subtractor for a 10-bit float format (4-bit exponent, 6-bit fraction, hidden one).
// Produces |a - b| truncated, with borrow (a < b) and underflow (result below 1.0) flags.
module fp_sub_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [9:0] a,
  input  logic [9:0] b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [9:0] s,
  output logic       borrow,
  output logic       uflow
);

  localparam int unsigned EW = 4;
  localparam int unsigned FW = 6;
  localparam int unsigned MW = FW + 1;
  localparam int unsigned W  = EW + FW;

  typedef enum logic [2:0] {IDLE, ALIGN, SUB, NORM, DONE} state_t;

  state_t        state, state_d;
  logic [MW-1:0] big_m, big_m_d, small_m, small_m_d, diff, diff_d;
  logic [EW-1:0] exp_q, exp_d, cnt, cnt_d;
  logic          swap, swap_d;
  logic [W-1:0]  s_d;
  logic          borrow_d, uflow_d;
  logic          swap_c;
  logic [W-1:0]  big_op_c, small_op_c;

  // Operand ordering: plain unsigned compare matches value order for this format.
  assign swap_c     = (a < b);
  assign big_op_c   = swap_c ? b : a;
  assign small_op_c = swap_c ? a : b;

  // Next-state and datapath update.
  always_comb begin
    state_d   = state;
    big_m_d   = big_m;
    small_m_d = small_m;
    diff_d    = diff;
    exp_d     = exp_q;
    cnt_d     = cnt;
    swap_d    = swap;
    s_d       = s;
    borrow_d  = borrow;
    uflow_d   = uflow;
    case (state)
      IDLE: begin
        if (in_valid) begin
          swap_d    = swap_c;
          big_m_d   = {1'b1, big_op_c[FW-1:0]};
          small_m_d = {1'b1, small_op_c[FW-1:0]};
          exp_d     = big_op_c[W-1:FW];
          cnt_d     = EW'(big_op_c[W-1:FW] - small_op_c[W-1:FW]);
          state_d   = ALIGN;
        end
      end
      ALIGN: begin
        if (cnt != '0) begin
          small_m_d = small_m >> 1;
          cnt_d     = cnt - EW'(1);
        end else begin
          state_d = SUB;
        end
      end
      SUB: begin
        diff_d  = big_m - small_m;
        state_d = NORM;
      end
      NORM: begin
        if (diff == '0 || (!diff[MW-1] && exp_q == '0)) begin
          s_d      = '0;
          uflow_d  = 1'b1;
          borrow_d = swap;
          state_d  = DONE;
        end else if (diff[MW-1]) begin
          s_d      = {exp_q, diff[FW-1:0]};
          uflow_d  = 1'b0;
          borrow_d = swap;
          state_d  = DONE;
        end else begin
          diff_d = diff << 1;
          exp_d  = exp_q - EW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      big_m     <= '0;
      small_m   <= '0;
      diff      <= '0;
      exp_q     <= '0;
      cnt       <= '0;
      swap      <= 1'b0;
      s         <= '0;
      borrow    <= 1'b0;
      uflow     <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      big_m     <= big_m_d;
      small_m   <= small_m_d;
      diff      <= diff_d;
      exp_q     <= exp_d;
      cnt       <= cnt_d;
      swap      <= swap_d;
      s         <= s_d;
      borrow    <= borrow_d;
      uflow     <= uflow_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_fp_sub_seq.sv
// Randomized bench for fp_sub_seq against a value-level model of |a - b| with normalization.
module tb_fp_sub_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [9:0] a, b, s;
  logic       borrow, uflow;

  int n_vec = 0;
  int n_err = 0;

  fp_sub_seq dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .borrow(borrow), .uflow(uflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: mantissas as integers, alignment as a truncating right shift,
  // normalization by locating the leading one. lat counts edges incl. the accept edge.
  task automatic model(input logic [9:0] ma, input logic [9:0] mb,
                       output logic [9:0] es, output logic eb_o, output logic eu, output int lat);
    int bg, sm, ebig, esml, sh, mbig, msml, d, p, need, k;
    eb_o = (ma < mb);
    bg   = eb_o ? int'(mb) : int'(ma);
    sm   = eb_o ? int'(ma) : int'(mb);
    ebig = bg / 64;
    esml = sm / 64;
    sh   = ebig - esml;
    mbig = 64 + bg % 64;
    msml = (64 + sm % 64) >> sh;
    d    = mbig - msml;
    es   = '0;
    eu   = 1'b1;
    k    = 0;
    if (d != 0) begin
      p = 0;
      for (int i = 0; i < 7; i++) if ((d >> i) % 2 == 1) p = i;
      need = 6 - p;
      if (need > ebig) begin
        k = ebig;
      end else begin
        k  = need;
        eu = 1'b0;
        es = 10'((ebig - need) * 64 + ((d << need) % 64));
      end
    end
    lat = sh + k + 4;
  endtask

  task automatic run_op(input logic [9:0] ta, input logic [9:0] tb_v, input int hold);
    logic [9:0] es;
    logic       eb, eu;
    int         lat, edges;
    model(ta, tb_v, es, eb, eu, lat);
    chk("idle_in_ready", 32'(in_ready), 1);
    out_ready = (hold == 0);
    a = ta; b = tb_v; in_valid = 1'b1;
    @(posedge clk); #1;
    edges = 1;
    chk("busy_in_ready", 32'(in_ready), 0);
    while (!out_valid && edges < 60) begin
      in_valid = 1'($urandom); a = 10'($urandom); b = 10'($urandom);
      @(posedge clk); #1;
      edges++;
    end
    in_valid = 1'b0;
    chk("out_valid", 32'(out_valid), 1);
    chk("latency", 32'(edges), 32'(lat));
    chk("s", 32'(s), 32'(es));
    chk("borrow", 32'(borrow), 32'(eb));
    chk("uflow", 32'(uflow), 32'(eu));
    chk("done_in_ready", 32'(in_ready), 0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'($urandom); a = 10'($urandom); b = 10'($urandom);
      @(posedge clk); #1;
      chk("hold_valid", 32'(out_valid), 1);
      chk("hold_s", 32'(s), 32'(es));
      chk("hold_flags", {30'd0, borrow, uflow}, {30'd0, eb, eu});
      chk("hold_in_ready", 32'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", 32'(in_ready), 1);
    chk("release_valid", 32'(out_valid), 0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_s", 32'(s), 0);
    chk("rst_flags", {30'd0, borrow, uflow}, 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(in_ready), 1);

    run_op(10'b0001_000000, 10'b0000_000000, 0);
    run_op(10'b0000_000000, 10'b0010_000000, 0);
    run_op(10'b0011_101000, 10'b0011_101000, 0);
    run_op(10'b0000_100000, 10'b0000_000000, 0);
    run_op(10'b0101_110011, 10'b0100_011001, 5);
    run_op(10'b1111_000000, 10'b0000_000000, 0);
    run_op(10'b0000_000001, 10'b1111_111111, 1);

    for (int i = 0; i < 60; i++) run_op(10'($urandom), 10'($urandom), int'($urandom_range(0, 2)));
    for (int i = 0; i < 20; i++) begin
      logic [9:0] ra;
      ra = 10'($urandom);
      run_op(ra, {ra[9:6], 6'($urandom)}, 0);
    end

    // Abort mid-ALIGN: result must never surface.
    out_ready = 1'b1;
    a = 10'b1111_000000; b = 10'b0000_000000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("abort_out_valid", 32'(out_valid), 0);
    chk("abort_s", 32'(s), 0);
    chk("abort_in_ready", 32'(in_ready), 1);
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      chk("no_stale_valid", 32'(out_valid), 0);
    end
    run_op(10'b0010_010000, 10'b0001_110000, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fp_sub_seq.md
FP_SUB_SEQ -- requirements
Module: fp_sub_seq

Interface
REQ-001 The block SHALL use one clock and one reset; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; forces the reset state immediately.
REQ-004 in_valid  input  1  operand pair on a/b is valid.
REQ-005 in_ready  output  1  block accepts an operand pair; high only in IDLE.
REQ-006 a  input  10  minuend; [9:6] exponent e (unsigned), [5:0] fraction f; value = (1 + f/64) * 2^e.
REQ-007 b  input  10  subtrahend, same format as a.
REQ-008 out_valid  output  1  s/borrow/uflow valid; high only in DONE.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 s  output  10  |a - b| in the same format, truncated.
REQ-011 borrow  output  1  a < b; operands were swapped, so s = b - a.
REQ-012 uflow  output  1  the truncated difference is below 1.0, including exact zero; s = 0 in that case.

Function
REQ-013 The FSM SHALL have the states IDLE, ALIGN, SUB, NORM and DONE.
REQ-014 Acceptance occurs on a clk edge with IDLE && in_valid; that edge is cycle 0 and the next state is ALIGN.
REQ-015 On acceptance the block SHALL perform these steps:
  - compare a and b as 10-bit unsigned values;
  - if a < b, set borrow=1 and swap the operands, else set borrow=0;
  - load the larger operand as big and the smaller as small;
  - form 7-bit mantissas {1,f} for each;
  - set the exponent register to big.e;
  - set the counter cnt = big.e - small.e (4-bit, 0..15).
REQ-016 ALIGN SHALL act once per cycle:
  - if cnt != 0, shift small.mantissa right by 1 with zero fill, truncate, and decrement cnt;
  - if cnt == 0, go to SUB.
  - ALIGN therefore lasts cnt+1 cycles.
REQ-017 SUB (1 cycle) SHALL compute diff = big.mantissa - small.mantissa (7-bit, no wrap, since big >= small by construction) and go to NORM.
REQ-018 NORM SHALL act once per cycle:
  - if diff == 0, set s=0 and uflow=1, then go to DONE;
  - if diff[6] == 1, set s = {exp, diff[5:0]} and uflow=0, then go to DONE;
  - if diff[6] == 0 and exp == 0, set s=0 and uflow=1, then go to DONE;
  - otherwise, shift diff left by 1, decrement exp, and stay in NORM.
REQ-019 Latency from acceptance to first out_valid SHALL be cnt + k + 4 cycles, where k is the number of NORM shifts.
REQ-020 DONE SHALL hold s, borrow, uflow and out_valid=1 stable until out_ready is high on a clk edge, then go to IDLE.
REQ-021 Outside IDLE, in_valid, a and b SHALL be ignored; no operand is captured.
REQ-022 out_valid and in_ready SHALL never be high in the same cycle; back-to-back acceptance is possible on the edge after the DONE handshake.
REQ-023 s, borrow and uflow SHALL be registered and change only on entry to DONE or on reset.
REQ-024 A shift of 15 in ALIGN (mantissa fully shifted out) SHALL be legal; small.mantissa becomes 0 and diff = big.mantissa.

Reset
REQ-025 On reset the block SHALL immediately (asynchronously) force: state=IDLE, out_valid=0, s=0, borrow=0, uflow=0, cnt=0, and all datapath registers 0.
REQ-026 in_ready SHALL read 1 while reset is high and in the first cycle after release.
REQ-027 Reset asserted in any non-IDLE state SHALL abort the operation with no result delivered; the next acceptance starts clean.

Verification
REQ-028 a=0001_000000 (2.0), b=0000_000000 (1.0), out_ready=1 -> s=0000_000000, borrow=0, uflow=0; out_valid high at cycle 6 (cnt=1, k=1).
REQ-029 a=0000_000000 (1.0), b=0010_000000 (4.0) -> s=0001_100000 (3.0), borrow=1, uflow=0; out_valid at cycle 7 (cnt=2, k=1).
REQ-030 a=b=0011_101000 -> s=0, uflow=1, borrow=0; out_valid at cycle 4.
REQ-031 a=0000_100000 (1.5), b=0000_000000 (1.0) -> diff 0.5 < 1.0 -> s=0, uflow=1, borrow=0.
REQ-032 Backpressure and reset:
  - hold out_ready=0 for 5 cycles in DONE while toggling in_valid/a/b: s, borrow, uflow and out_valid=1 stay stable and in_ready=0; raising out_ready returns the block to IDLE on the next edge.
  - assert reset mid-ALIGN with a=1111_000000, b=0000_000000: out_valid=0, s=0 and in_ready=1 immediately, and no stale result appears afterward.
